fetch_queue_unit: RTL and testbench

// - Instruction-fetch producer feeding the IF/ID pipeline register (InstrF/PC pair into decode).
// - Owns the fetch PC and issues in-order requests to instruction memory.
// - Buffers returned words in a small FIFO so memory latency and decode stalls are decoupled.
// - Honours branch redirects from execute by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_queue_unit_if.sv | 12 +
 rtl/fetch_queue_unit.sv | 106 ++++++++++
 tb/tb_fetch_queue_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface fetch_queue_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_gnt, imem_valid, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_gnt, imem_valid, imem_rdata);
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch queue: owns the fetch PC, issues in-order imem requests and buffers words for decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  fetch_queue_unit_if.master  mem_bus,
  input  logic                StallF,
  input  logic                BranchTakenE,
  input  logic [31:0]         BranchTargetE,
  output logic [31:0]         InstrF,
  output logic [31:0]         PcF,
  output logic                ValidF
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        q [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, inflight, drop;
  logic [31:0]   pc_q, resp_pc;
  logic [CW:0]   credit;
  logic          issue, keep, push, pop, q_valid, byp_take;

  // in-flight plus queued words never exceed DEPTH, so a push always finds room
  assign credit            = {1'b0, inflight} + {1'b0, count};
  assign mem_bus.imem_req  = !reset && !BranchTakenE && (credit < (CW+1)'(DEPTH));
  assign mem_bus.imem_addr = pc_q;
  assign issue             = mem_bus.imem_req && mem_bus.imem_gnt;

  // stale words are always older than live ones, so drop==0 marks a live response
  assign keep    = mem_bus.imem_valid && (drop == '0) && !BranchTakenE && !reset;
  assign q_valid = (count != '0);
  assign head    = q[rd_ptr];
  assign pop     = q_valid && !StallF && !BranchTakenE;

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp      = !q_valid && keep;
  assign byp_take = byp && !StallF;
  assign ValidF   = q_valid || byp;
  always_comb begin
    InstrF = '0;
    PcF    = '0;
    if (q_valid) begin
      InstrF = head.instr;
      PcF    = head.pc;
    end else if (byp) begin
      InstrF = mem_bus.imem_rdata;
      PcF    = resp_pc;
    end
  end
`else
  assign byp_take = 1'b0;
  assign ValidF   = q_valid;
  assign InstrF   = q_valid ? head.instr : '0;
  assign PcF      = q_valid ? head.pc    : '0;
`endif

  assign push = keep && !byp_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(mem_bus.imem_valid);
      if (BranchTakenE) begin
        pc_q    <= BranchTargetE;
        resp_pc <= BranchTargetE;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        // a response landing this cycle is discarded by the redirect itself
        drop    <= inflight - CW'(mem_bus.imem_valid);
      end else begin
        if (issue) pc_q <= pc_q + 32'd4;
        if (mem_bus.imem_valid && drop != '0) drop <= drop - CW'(1);
        if (keep) resp_pc <= resp_pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= '{instr: mem_bus.imem_rdata, pc: resp_pc};
  end

  push_fits: assert property (@(posedge clk) disable iff (reset) !(push && count == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: stimulus table, directed redirect/wrap sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_queue_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_unit_if bus ();
  fetch_queue_unit_if bus_w ();

  logic        StallF, BranchTakenE, ValidF;
  logic [31:0] BranchTargetE, InstrF, PcF;
  logic        stall_w, br_w, ValidF_w;
  logic [31:0] tgt_w, InstrF_w, PcF_w;

  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_bus(bus),
    .StallF(StallF), .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .InstrF(InstrF), .PcF(PcF), .ValidF(ValidF));

  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFFFFF8)) dut_wrap (
    .clk(clk), .reset(reset), .mem_bus(bus_w),
    .StallF(stall_w), .BranchTakenE(br_w), .BranchTargetE(tgt_w),
    .InstrF(InstrF_w), .PcF(PcF_w), .ValidF(ValidF_w));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // reference model: outstanding memory requests and the words decode has yet to take
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] rq[$];
  logic [31:0] fetch_pc;
  int          cyc, lat_lo, lat_hi, gnt_pct;
  logic        obs_vf, obs_req;
  logic [31:0] obs_pc, obs_instr, obs_addr;

  task automatic step(input bit stall, input bit br, input logic [31:0] tgt);
    bit          resp, stale, exp_vf, exp_req, g, consumed;
    logic [31:0] raddr, exp_pc;
    int          due;
    g        = ($urandom_range(99) < gnt_pct);
    resp     = (pend.size() > 0) && (pend[0].due <= cyc);
    raddr    = resp ? pend[0].addr : 32'h0;
    stale    = resp ? pend[0].stale : 1'b0;
    consumed = 1'b0;
    StallF = stall; BranchTakenE = br; BranchTargetE = tgt;
    bus.imem_gnt   = g;
    bus.imem_valid = resp;
    bus.imem_rdata = resp ? (raddr ^ KEY) : $urandom;
    #1;
    exp_req = !br && (pend.size() + rq.size() < DEPTH);
    exp_vf  = 1'b0;
    exp_pc  = 32'h0;
    if (rq.size() > 0) begin
      exp_vf = 1'b1; exp_pc = rq[0];
    end
`ifdef FETCH_BYPASS_EN
    else if (resp && !stale && !br) begin
      exp_vf = 1'b1; exp_pc = raddr;
    end
`endif
    obs_vf = ValidF; obs_pc = PcF; obs_instr = InstrF;
    obs_req = bus.imem_req; obs_addr = bus.imem_addr;
    check("imem_req", bus.imem_req, exp_req);
    check("imem_addr", bus.imem_addr, fetch_pc);
    check("ValidF", ValidF, exp_vf);
    check("PcF", PcF, exp_pc);
    check("InstrF", InstrF, exp_vf ? (exp_pc ^ KEY) : 32'h0);
    if (resp) pend.delete(0);
    if (br) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      rq.delete();
      fetch_pc = tgt;
    end else begin
      if (exp_vf && !stall) begin
        if (rq.size() > 0) rq.delete(0);
        else consumed = 1'b1;
      end
      if (resp && !stale && !consumed) rq.push_back(raddr);
      if (exp_req && g) begin
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (pend.size() > 0 && pend[$].due >= due) due = pend[$].due + 1;
        pend.push_back('{fetch_pc, due, 1'b0});
        fetch_pc = fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    StallF = 1'b0; BranchTakenE = 1'b0; BranchTargetE = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_valid = 1'b0; bus.imem_rdata = 32'h0;
    stall_w = 1'b0; br_w = 1'b0; tgt_w = 32'h0;
    bus_w.imem_gnt = 1'b0; bus_w.imem_valid = 1'b0; bus_w.imem_rdata = 32'h0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_ValidF", ValidF, 32'h0);
    check("rst_InstrF", InstrF, 32'h0);
    check("rst_PcF", PcF, 32'h0);
    check("rst_imem_req", bus.imem_req, 32'h0);
    check("rst_wrap_ValidF", ValidF_w, 32'h0);
    reset = 1'b0;
    pend.delete(); rq.delete();
    fetch_pc = 32'h0;
    cyc = 0;
  endtask

  typedef struct {
    bit          stall;
    bit          req;
    logic [31:0] addr;
    bit          vf_nb;
    bit          vf_by;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found, vf_exp;
    logic [31:0] prev;
    logic [31:0] wexp[3];
    logic [31:0] seen[$];
    bit          pv;
    logic [31:0] pa;
    int          first;

    // stall from reset until full, then release (1-cycle memory, grant every cycle)
    tbl[0]  = '{1, 1, 32'd0,  0, 0, 32'd0};
    tbl[1]  = '{1, 1, 32'd4,  0, 1, 32'd0};
    tbl[2]  = '{1, 1, 32'd8,  1, 1, 32'd0};
    tbl[3]  = '{1, 1, 32'd12, 1, 1, 32'd0};
    for (int i = 4; i < 10; i++) tbl[i] = '{1, 0, 32'd16, 1, 1, 32'd0};
    tbl[10] = '{0, 0, 32'd16, 1, 1, 32'd0};
    tbl[11] = '{0, 1, 32'd16, 1, 1, 32'd4};
    tbl[12] = '{0, 1, 32'd20, 1, 1, 32'd8};
    tbl[13] = '{0, 1, 32'd24, 1, 1, 32'd12};
    tbl[14] = '{0, 1, 32'd28, 1, 1, 32'd16};

    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    do_reset(2);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].stall, 1'b0, 32'h0);
`ifdef FETCH_BYPASS_EN
      vf_exp = tbl[i].vf_by;
`else
      vf_exp = tbl[i].vf_nb;
`endif
      check($sformatf("tbl%0d_req", i), obs_req, tbl[i].req);
      check($sformatf("tbl%0d_addr", i), obs_addr, tbl[i].addr);
      check($sformatf("tbl%0d_vf", i), obs_vf, vf_exp);
      check($sformatf("tbl%0d_pc", i), obs_pc, tbl[i].pc);
      check($sformatf("tbl%0d_instr", i), obs_instr, vf_exp ? (tbl[i].pc ^ KEY) : 32'h0);
    end

    // steady streaming: one new PC every cycle, no gaps
    prev = 32'd16;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 32'h0);
      check("stream_vf", obs_vf, 32'h1);
      check("stream_pc", obs_pc, prev + 32'd4);
      prev = prev + 32'd4;
    end

    // redirect with two responses outstanding at 3-cycle latency
    lat_lo = 3; lat_hi = 3;
    do_reset(1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b0, 32'h0);
    check("t4_vf_after_redirect", obs_vf, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b0, 32'h0);
      if (obs_vf) begin
        found = 1'b1;
        check("t4_first_pc", obs_pc, 32'h100);
      end
    end
    check("t4_found", found, 32'h1);

    // redirect coinciding with a response and a pop
    lat_lo = 2; lat_hi = 2;
    do_reset(1);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200);
    check("t5_head_at_redirect", obs_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("t5_vf_after_redirect", obs_vf, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b0, 32'h0);
      if (obs_vf) begin
        found = 1'b1;
        check("t5_first_pc", obs_pc, 32'h200);
      end
    end
    check("t5_found", found, 32'h1);

    // randomized traffic with a mid-run reset
    lat_lo = 1; lat_hi = 3; gnt_pct = 75;
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      if (i == 1500) do_reset(1);
      t = ($urandom_range(3) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
      step($urandom_range(99) < 30, $urandom_range(99) < 3, t);
    end

    // PC wrap from RESET_PC near the top of the address space
    do_reset(2);
    wexp[0] = 32'hFFFFFFF8; wexp[1] = 32'hFFFFFFFC; wexp[2] = 32'h0;
    pv = 1'b0; pa = 32'h0; first = -1;
    for (int k = 0; k < 10; k++) begin
      bus_w.imem_gnt   = 1'b1;
      bus_w.imem_valid = pv;
      bus_w.imem_rdata = pa ^ KEY;
      #1;
      if (ValidF_w) begin
        if (first < 0) first = k;
        if (seen.size() < 3) check("wrap_instr", InstrF_w, wexp[seen.size()] ^ KEY);
        seen.push_back(PcF_w);
      end
      pv = bus_w.imem_req;
      pa = bus_w.imem_addr;
      @(posedge clk);
      #1;
    end
`ifdef FETCH_BYPASS_EN
    check("wrap_first_valid_cycle", first, 32'd1);
`else
    check("wrap_first_valid_cycle", first, 32'd2);
`endif
    check("wrap_count", (seen.size() >= 3), 32'h1);
    for (int k = 0; k < 3; k++)
      check($sformatf("wrap_pc%0d", k), (seen.size() > k) ? seen[k] : 32'hDEADBEEF, wexp[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
